// File: rtl/sound_pkg.sv
// Shared types and helpers for the tone mixer: envelope state encoding and mid-scale offset.
package sound_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  // Offset-binary zero point for an output of the given width.
  function automatic int unsigned mid_scale(input int unsigned out_w);
    return 32'd1 << (out_w - 32'd1);
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone voice: square-wave phase generator plus tick-paced ADSR-style envelope.
module tone_channel
  import sound_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned AMP_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_switch,
  input  logic                i_wr,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [AMP_W-1:0]    i_amp,
  output logic [AMP_W-1:0]    o_env,
  output logic                o_phase,
  output logic                o_active
);

  localparam int unsigned INC_W = AMP_W + 1;

  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic [AMP_W-1:0]    r_amp;
  logic                r_phase;
  env_state_e          r_state;
  logic [AMP_W-1:0]    r_env;

  env_state_e          w_state_nxt;
  logic [AMP_W-1:0]    w_env_nxt;
  logic [INC_W-1:0]    w_env_inc;
  logic                w_att_done;
  logic [AMP_W-1:0]    w_att_env;
  env_state_e          w_att_state;
  logic [AMP_W-1:0]    w_rel_env;
  env_state_e          w_rel_state;

  // Square generator; a config write restarts the half-period but keeps phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_amp    <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (i_wr) begin
      r_period <= i_period;
      r_amp    <= i_amp;
      r_cnt    <= '0;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (r_cnt == r_period - PERIOD_W'(1)) begin
      r_cnt    <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt + PERIOD_W'(1);
    end
  end

  // One attack or release step, applied on the same tick the direction is chosen.
  assign w_env_inc   = INC_W'(r_env) + INC_W'(1);
  assign w_att_done  = (w_env_inc >= INC_W'(r_amp));
  assign w_att_env   = w_att_done ? r_amp : (r_env + AMP_W'(1));
  assign w_att_state = w_att_done ? ENV_SUSTAIN : ENV_ATTACK;
  assign w_rel_env   = (r_env == '0) ? '0 : (r_env - AMP_W'(1));
  assign w_rel_state = (r_env <= AMP_W'(1)) ? ENV_IDLE : ENV_RELEASE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENV_IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (i_tick) begin
      case (r_state)
        ENV_IDLE: begin
          w_env_nxt = '0;
          if (i_switch) begin
            w_state_nxt = w_att_state;
            w_env_nxt   = w_att_env;
          end
        end
        ENV_ATTACK: begin
          w_state_nxt = i_switch ? w_att_state : w_rel_state;
          w_env_nxt   = i_switch ? w_att_env   : w_rel_env;
        end
        ENV_SUSTAIN: begin
          if (!i_switch) begin
            w_state_nxt = w_rel_state;
            w_env_nxt   = w_rel_env;
          end else if (r_amp < r_env) begin
            w_env_nxt   = r_amp;
          end else if (r_amp > r_env) begin
            w_state_nxt = w_att_state;
            w_env_nxt   = w_att_env;
          end
        end
        ENV_RELEASE: begin
          w_state_nxt = i_switch ? w_att_state : w_rel_state;
          w_env_nxt   = i_switch ? w_att_env   : w_rel_env;
        end
        default: begin
          w_state_nxt = ENV_IDLE;
          w_env_nxt   = '0;
        end
      endcase
    end
  end

  assign o_env    = r_env;
  assign o_phase  = r_phase;
  assign o_active = (r_period != '0);

endmodule

// File: rtl/sound_mixer_n.sv
// N-voice square-wave mixer: sums signed voice contributions and emits a clamped offset-binary sample.
module sound_mixer_n
  import sound_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned AMP_W      = 6,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned SAMPLE_DIV = 16,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   switches,
  input  logic                cfg_wr,
  input  logic                cfg_all,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [AMP_W-1:0]    cfg_amp,
  output logic [OUT_W-1:0]    combined,
  output logic                sample_valid
);

  localparam int unsigned SUM_W   = AMP_W + 1 + $clog2(NUM_CH);
  localparam int unsigned EXT_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 2;
  localparam int unsigned TICK_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned MID     = mid_scale(OUT_W);
  localparam int unsigned OUT_MAX = (32'd1 << OUT_W) - 32'd1;

  logic [TICK_W-1:0]              r_tick_cnt;
  logic                           w_tick;
  logic [NUM_CH-1:0]              w_wr;
  logic [NUM_CH-1:0][AMP_W-1:0]   w_env;
  logic [NUM_CH-1:0]              w_phase;
  logic [NUM_CH-1:0]              w_active;
  logic signed [SUM_W-1:0]        w_sum;
  logic signed [EXT_W-1:0]        w_biased;
  logic [OUT_W-1:0]               w_clamped;
  logic [OUT_W-1:0]               r_combined;
  logic                           r_valid;

  assign w_tick = (r_tick_cnt == TICK_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = cfg_wr & (cfg_all | (cfg_ch == CH_W'(i)));

    tone_channel #(
      .PERIOD_W (PERIOD_W),
      .AMP_W    (AMP_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_tick   (w_tick),
      .i_switch (switches[i]),
      .i_wr     (w_wr[i]),
      .i_period (cfg_period),
      .i_amp    (cfg_amp),
      .o_env    (w_env[i]),
      .o_phase  (w_phase[i]),
      .o_active (w_active[i])
    );
  end

  // Silent (period 0) voices are excluded; others add +env or -env by phase.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_active[i]) begin
        if (w_phase[i]) begin
          w_sum = w_sum + $signed(SUM_W'(w_env[i]));
        end else begin
          w_sum = w_sum - $signed(SUM_W'(w_env[i]));
        end
      end
    end
  end

  assign w_biased = EXT_W'(w_sum) + $signed(EXT_W'(MID));

  always_comb begin
    w_clamped = OUT_W'(w_biased);
    if (w_biased[EXT_W-1]) begin
      w_clamped = '0;
    end else if (w_biased > $signed(EXT_W'(OUT_MAX))) begin
      w_clamped = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_combined <= OUT_W'(MID);
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_tick;
      if (w_tick) begin
        r_combined <= w_clamped;
      end
    end
  end

  assign combined     = r_combined;
  assign sample_valid = r_valid;

endmodule

// File: tb/tb_sound_mixer_n.sv
// Directed bench for sound_mixer_n with default parameters (4 voices, 8-bit out, 16-cycle samples).
module tb_sound_mixer_n;

  logic        clk;
  logic        rst_n;
  logic [3:0]  switches;
  logic        cfg_wr;
  logic        cfg_all;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [5:0]  cfg_amp;
  logic [7:0]  combined;
  logic        sample_valid;

  int          n_pass;
  int          n_fail;
  int          n_total;
  logic [7:0]  s;
  logic [7:0]  prev;

  sound_mixer_n dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switches     (switches),
    .cfg_wr       (cfg_wr),
    .cfg_all      (cfg_all),
    .cfg_ch       (cfg_ch),
    .cfg_period   (cfg_period),
    .cfg_amp      (cfg_amp),
    .combined     (combined),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge inside the sample_valid pulse.
  task automatic wait_sample(output logic [7:0] v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sample_valid !== 1'b1 && k < 40);
    check8("sample_pulse", 8'(sample_valid), 8'h01);
    v = combined;
  endtask

  task automatic cfg_write(input logic all, input logic [1:0] ch,
                           input logic [15:0] per, input logic [5:0] amp);
    cfg_wr     = 1'b1;
    cfg_all    = all;
    cfg_ch     = ch;
    cfg_period = per;
    cfg_amp    = amp;
    @(negedge clk);
    cfg_wr     = 1'b0;
    cfg_all    = 1'b0;
  endtask

  function automatic logic [7:0] dev(input logic [7:0] c);
    return (c >= 8'h80) ? (c - 8'h80) : (8'h80 - c);
  endfunction

  initial begin
    #4000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    switches = 4'b0000; cfg_wr = 1'b0; cfg_all = 1'b0; cfg_ch = 2'd0;
    cfg_period = 16'd0; cfg_amp = 6'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check8("rst_combined_async", combined, 8'h80);
    check8("rst_valid_async", 8'(sample_valid), 8'h00);
    repeat (3) @(negedge clk);
    check8("rst_combined_held", combined, 8'h80);
    check8("rst_valid_held", 8'(sample_valid), 8'h00);
    rst_n = 1'b1;

    wait_sample(s);
    check8("idle_mix", s, 8'h80);

    // Single voice attack to amp 10: first sample shows the pre-tick env of 0.
    switches = 4'b0001;
    cfg_write(1'b0, 2'd0, 16'd16, 6'd10);
    for (int e = 0; e <= 10; e++) begin
      wait_sample(s);
      check8($sformatf("attack_env%0d", e), dev(s), 8'(e));
    end
    prev = s;
    for (int n = 0; n < 4; n++) begin
      wait_sample(s);
      check8("sustain_alt", s, (prev == 8'h8A) ? 8'h76 : 8'h8A);
      prev = s;
    end

    // Full release to idle.
    switches = 4'b0000;
    for (int e = 10; e >= 0; e--) begin
      wait_sample(s);
      check8($sformatf("release_env%0d", e), dev(s), 8'(e));
    end
    for (int n = 0; n < 2; n++) begin
      wait_sample(s);
      check8("released_idle", s, 8'h80);
    end

    // Re-attack, then interrupt the release at env 5.
    switches = 4'b0001;
    repeat (11) wait_sample(s);
    check8("reattack_top", dev(s), 8'd10);
    switches = 4'b0000;
    for (int e = 10; e >= 6; e--) begin
      wait_sample(s);
      check8($sformatf("partial_rel_env%0d", e), dev(s), 8'(e));
    end
    switches = 4'b0001;
    for (int e = 5; e <= 10; e++) begin
      wait_sample(s);
      check8($sformatf("resume_env%0d", e), dev(s), 8'(e));
    end
    wait_sample(s);
    check8("resume_sustain", dev(s), 8'd10);

    // All voices at full amplitude with aligned phases: output clamps to rails.
    switches = 4'b1111;
    cfg_write(1'b1, 2'd0, 16'd0, 6'd63);
    @(negedge clk);
    cfg_write(1'b1, 2'd0, 16'd16, 6'd63);
    repeat (68) wait_sample(s);
    prev = s;
    for (int n = 0; n < 4; n++) begin
      wait_sample(s);
      check8("clamp_alt", s, (prev == 8'hFF) ? 8'h00 : 8'hFF);
      prev = s;
    end

    // Reset in the middle of a release leaves nothing behind.
    switches = 4'b0000;
    repeat (10) wait_sample(s);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check8("midrel_rst_combined", combined, 8'h80);
    check8("midrel_rst_valid", 8'(sample_valid), 8'h00);
    repeat (2) @(negedge clk);
    switches = 4'b1111;
    rst_n = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_sample(s);
      check8("post_reset_clean", s, 8'h80);
    end

    // Zero period: silent output while the envelope still climbs to 20.
    switches = 4'b0001;
    cfg_write(1'b0, 2'd0, 16'd0, 6'd20);
    for (int n = 0; n < 22; n++) begin
      wait_sample(s);
      check8($sformatf("zero_period_%0d", n), s, 8'h80);
    end
    cfg_write(1'b0, 2'd0, 16'd16, 6'd20);
    wait_sample(s);
    check8("zero_period_env_ramped", s, 8'h6C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sound_mixer_n.md
SOUND_MIXER_N -- requirements
Module: sound_mixer_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of tone channels.
REQ-002 SHALL have parameter PERIOD_W, default 16, half-period counter width.
REQ-003 SHALL have parameter AMP_W, default 6, amplitude/envelope width; AMP_W <= OUT_W-1.
REQ-004 SHALL have parameter OUT_W, default 8, output sample width.
REQ-005 SHALL have parameter SAMPLE_DIV, default 16, clk cycles per output sample.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port switches, input, NUM_CH, per-channel note on (1) / off (0).
REQ-009 SHALL have port cfg_wr, input, 1, config write strobe.
REQ-010 SHALL have port cfg_all, input, 1, write applies to every channel.
REQ-011 SHALL have port cfg_ch, input, clog2(NUM_CH), target channel when cfg_all=0.
REQ-012 SHALL have port cfg_period, input, PERIOD_W, half-period in clk cycles.
REQ-013 SHALL have port cfg_amp, input, AMP_W, target amplitude.
REQ-014 SHALL have port combined, output, OUT_W, offset-binary mixed sample.
REQ-015 SHALL have port sample_valid, output, 1, one-cycle pulse when combined updates.

Function
REQ-016 Tick counter SHALL count 0..SAMPLE_DIV-1 and assert an internal tick on SAMPLE_DIV-1.
REQ-017 Per channel: cnt increments each clk; at cnt==period-1, cnt<=0 and phase toggles.
REQ-018 period==0 SHALL hold cnt=0, phase=0; the channel contributes 0 to the mix.
REQ-019 A cfg write SHALL load period/amp, clear cnt to 0 and leave phase unchanged; new values are visible from the next cycle.
REQ-020 Envelope FSM states: IDLE, ATTACK, SUSTAIN, RELEASE; transitions and env updates happen only on tick; switches are sampled on tick.
REQ-021 IDLE: env=0; switch=1 -> ATTACK.
REQ-022 ATTACK: env+1 per tick; if env>=amp then env<=amp and -> SUSTAIN; switch=0 -> RELEASE.
REQ-023 SUSTAIN: amp<env -> env<=amp; amp>env -> ATTACK; switch=0 -> RELEASE.
REQ-024 RELEASE: env-1 per tick; reaching 0 -> IDLE; switch=1 -> ATTACK, continuing from the current env.
REQ-025 When a cfg write and a tick coincide, the tick SHALL use the pre-write amp.
REQ-026 Contribution SHALL be +env when phase=1 and -env when phase=0, computed as a signed sum of width AMP_W+1+clog2(NUM_CH).
REQ-027 combined SHALL be 2^(OUT_W-1)+sum, clamped to [0, 2^OUT_W-1].
REQ-028 combined SHALL be registered on the tick cycle and appear the following cycle together with sample_valid=1.
REQ-029 sample_valid SHALL be 0 in all other cycles.

Reset
REQ-030 rst_n=0 SHALL immediately force combined=2^(OUT_W-1) (0x80), sample_valid=0, all env=0, all FSMs IDLE, phase=0, cnt=0, period=0, amp=0, and tick counter=0.
REQ-031 Reset asserted mid-attack or mid-release SHALL abort the operation with no residual state.

Structure
REQ-032 Package sound_pkg SHALL hold the envelope state enum and the mid-scale constant function.
REQ-033 Sub-module tone_channel (square generator + envelope FSM) SHALL be instantiated NUM_CH times; mixer and clamp logic stay in the top module.

Verification (defaults: NUM_CH=4, OUT_W=8, AMP_W=6, SAMPLE_DIV=16)
REQ-034 Bench: rst_n low at any time -> combined=0x80 and sample_valid=0 in the same cycle.
REQ-035 Bench: ch0 period=16, amp=10, switches=0001 -> env ramps 1..10 over 10 ticks, then combined alternates 0x8A/0x76.
REQ-036 Bench: cfg_all write period=16, amp=63, switches=1111, after attack -> combined alternates 0xFF/0x00 (clamped at +/-252).
REQ-037 Bench: from REQ-035 sustain, switches=0000 -> env decrements 10..0 over 10 ticks; combined=0x80 thereafter; FSM IDLE.
REQ-038 Bench: in RELEASE at env=5, switch ch0 back to 1 -> ATTACK resumes and reaches SUSTAIN at 10 after 5 ticks.
REQ-039 Bench: ch0 period=0, amp=20, switch on -> combined stays 0x80 while env still ramps.
